// File: rtl/mux_4_1_arb_pkg.sv
// Shared types and constants for the 4-input mux arbiter.
package mux_4_1_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    // Binary owner index to one-hot grant vector.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_4_1_arb_rr_pick.sv
// Rotating-priority search: first set req bit at ptr+1, ptr+2, ptr+3, ptr.
module rr_pick
    import mux_4_1_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk the ring starting just after ptr; ptr itself is checked last.
    always_comb begin
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_4_1_arb.sv
// Round-robin arbiter owning the select lines of a 4:1 mux, with a
// bounded hold time per owner.
module mux_4_1_arb
    import mux_4_1_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic             s_0,
    output logic             s_1,
    output logic             busy
);

    localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] ptr_q;
    logic [2:0]       hold_q;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             rel_w;

    // ptr_q is the last owner; while in OWN it is also the current owner,
    // so one picker serves both initial grants and hand-offs.
    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Owner release condition: done, dropped request, or hold limit reached.
    always_comb begin
        rel_w = done || !req[ptr_q] || (hold_q == HOLD_LAST);
    end

    // Arbitration FSM with registered grant, select, pointer and hold count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= IDX_W'(N_REQ - 1);
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= OWN;
                        gnt_q   <= idx_to_onehot(pick_idx);
                        sel_q   <= pick_idx;
                        ptr_q   <= pick_idx;
                        hold_q  <= '0;
                    end
                end
                OWN: begin
                    if (rel_w) begin
                        if (pick_found) begin
                            gnt_q  <= idx_to_onehot(pick_idx);
                            sel_q  <= pick_idx;
                            ptr_q  <= pick_idx;
                            hold_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end else begin
                        hold_q <= hold_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign s_0  = sel_q[0];
    assign s_1  = sel_q[1];
    assign busy = |gnt_q;

endmodule

// File: tb/tb_mux_4_1_arb.sv
// Self-checking bench for mux_4_1_arb using an expected-value queue.
module tb_mux_4_1_arb;

    localparam int unsigned MAX_HOLD = 4;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       s_0;
    logic       s_1;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    mux_4_1_arb #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .done  (done),
        .gnt   (gnt),
        .s_0   (s_0),
        .s_1   (s_1),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue what the next edge must produce.
    task automatic drive(input logic [3:0] r, input logic d,
                         input logic [3:0] eg, input logic [1:0] es);
        exp_t e;
        @(negedge clk);
        req   = r;
        done  = d;
        e.gnt = eg;
        e.sel = es;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        e.gnt = 4'b0000;
        e.sel = 2'b00;
        sb.push_back(e);
        #3;
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt || {s_1, s_0} !== e.sel || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b busy=0",
                     gnt, {s_1, s_0}, busy, e.gnt, e.sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        exp_t e;
        for (int j = 0; j < 16; j++) begin
            drive(4'b1111, 1'b0, 4'b0001 << (j / 4), 2'(j / 4));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || {s_1, s_0} !== e.sel || busy !== (|e.gnt)) begin
                errors++;
                $display("FAIL rotation cyc %0d: gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b",
                         j, gnt, {s_1, s_0}, busy, e.gnt, e.sel);
            end
        end
    endtask

    task automatic test_idle_hold();
        exp_t e;
        for (int j = 0; j < 2; j++) begin
            drive(4'b0000, 1'b0, 4'b0000, 2'b11);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || {s_1, s_0} !== e.sel || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold cyc %0d: gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b busy=0",
                         j, gnt, {s_1, s_0}, busy, e.gnt, e.sel);
            end
        end
    endtask

    task automatic test_done_idle();
        exp_t e;
        for (int j = 0; j < 2; j++) begin
            drive(4'b0000, 1'b1, 4'b0000, 2'b11);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || {s_1, s_0} !== e.sel || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_idle cyc %0d: gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b",
                         j, gnt, {s_1, s_0}, busy, e.gnt, e.sel);
            end
        end
        done = 1'b0;
    endtask

    // Sole requester re-granted after done; a later competitor proves the hold count restarted.
    task automatic test_sole_done();
        logic [3:0] r_t [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0101,
                                4'b0101, 4'b0101, 4'b0101, 4'b0000};
        logic       d_t [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        logic [3:0] g_t [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
                                4'b0100, 4'b0100, 4'b0001, 4'b0000};
        logic [1:0] s_t [8] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
        exp_t e;
        for (int j = 0; j < 8; j++) begin
            drive(r_t[j], d_t[j], g_t[j], s_t[j]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || {s_1, s_0} !== e.sel || busy !== (|e.gnt)) begin
                errors++;
                $display("FAIL sole_done cyc %0d: gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b",
                         j, gnt, {s_1, s_0}, busy, e.gnt, e.sel);
            end
        end
    endtask

    task automatic test_handoff();
        logic [3:0] r_t [4] = '{4'b0010, 4'b1010, 4'b1000, 4'b0000};
        logic [3:0] g_t [4] = '{4'b0010, 4'b0010, 4'b1000, 4'b0000};
        logic [1:0] s_t [4] = '{2'd1, 2'd1, 2'd3, 2'd3};
        exp_t e;
        for (int j = 0; j < 4; j++) begin
            drive(r_t[j], 1'b0, g_t[j], s_t[j]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || {s_1, s_0} !== e.sel || busy !== (|e.gnt)) begin
                errors++;
                $display("FAIL handoff cyc %0d: gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b",
                         j, gnt, {s_1, s_0}, busy, e.gnt, e.sel);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        drive(4'b0100, 1'b0, 4'b0100, 2'd2);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt || {s_1, s_0} !== e.sel) begin
            errors++;
            $display("FAIL async_pre: gnt=%b sel=%b, expected gnt=%b sel=%b",
                     gnt, {s_1, s_0}, e.gnt, e.sel);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = '0;
        e.gnt = 4'b0000;
        e.sel = 2'd0;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt || {s_1, s_0} !== e.sel || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_drop: gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b busy=0",
                     gnt, {s_1, s_0}, busy, e.gnt, e.sel);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b1010, 1'b0, 4'b0010, 2'd1);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt || {s_1, s_0} !== e.sel || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_regrant: gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b",
                     gnt, {s_1, s_0}, busy, e.gnt, e.sel);
        end
    endtask

    // done coincides with hold expiry: exactly one hand-off, new owner keeps the mux.
    task automatic test_double_release();
        logic [3:0] r_t [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0000};
        logic       d_t [6] = '{0, 0, 0, 1, 0, 0};
        logic [3:0] g_t [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0000};
        logic [1:0] s_t [6] = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
        exp_t e;
        for (int j = 0; j < 6; j++) begin
            drive(r_t[j], d_t[j], g_t[j], s_t[j]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || {s_1, s_0} !== e.sel || busy !== (|e.gnt)) begin
                errors++;
                $display("FAIL double_release cyc %0d: gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b",
                         j, gnt, {s_1, s_0}, busy, e.gnt, e.sel);
            end
        end
    endtask

    // Random traffic against a behavioural model of the arbitration rules.
    task automatic test_random();
        bit         own_m  = 1'b0;
        int         own_i  = 0;
        int         ptr_m  = 3;
        int         hold_m = 0;
        logic [1:0] sel_m  = 2'd0;
        logic [3:0] r;
        logic       d;
        logic [3:0] eg;
        bit         rel;
        bit         fnd;
        int         c;
        exp_t       e;
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 300; j++) begin
            r   = 4'($urandom_range(0, 15));
            d   = ($urandom_range(0, 5) == 0);
            rel = !own_m || d || !r[own_i] || (hold_m == MAX_HOLD - 1);
            if (rel) begin
                fnd = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    c = (ptr_m + k) % 4;
                    if (!fnd && r[c]) begin
                        fnd = 1'b1;
                        own_i = c;
                    end
                end
                if (fnd) begin
                    own_m  = 1'b1;
                    ptr_m  = own_i;
                    hold_m = 0;
                    sel_m  = 2'(own_i);
                end else begin
                    own_m = 1'b0;
                end
            end else begin
                hold_m++;
            end
            eg = own_m ? (4'b0001 << own_i) : 4'b0000;
            drive(r, d, eg, sel_m);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt || {s_1, s_0} !== e.sel || busy !== (|e.gnt)) begin
                errors++;
                $display("FAIL random cyc %0d: req=%b done=%b gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b",
                         j, r, d, gnt, {s_1, s_0}, busy, e.gnt, e.sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_idle_hold();
        test_done_idle();
        test_sole_done();
        test_handoff();
        test_async_reset();
        test_double_release();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
